// File: rtl/prbs_pkg.sv
// Shared PRBS9 constants and the single-step LFSR function used by RTL and bench.
package prbs_pkg;

  localparam int unsigned    PRBS9_W            = 9;
  localparam int unsigned    PRBS9_TAP_HI       = 8;
  localparam int unsigned    PRBS9_TAP_LO       = 4;
  localparam logic [9-1:0]   PRBS9_DEFAULT_SEED = 9'h1FF;
  localparam int unsigned    PRBS9_PERIOD       = 511;

  // Fibonacci step for x^9 + x^5 + 1: shift left, feedback enters at the LSB.
  function automatic logic [PRBS9_W-1:0] prbs9_next(input logic [PRBS9_W-1:0] state);
    return {state[PRBS9_W-2:0], state[PRBS9_TAP_HI] ^ state[PRBS9_TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs9_lfsr_step.sv
// Combinational PRBS9 LFSR step: current state in, next state out.
module prbs9_lfsr_step
  import prbs_pkg::*;
(
  input  logic [PRBS9_W-1:0] state,
  output logic [PRBS9_W-1:0] next
);

  assign next = prbs9_next(state);

endmodule

// File: rtl/prbs9_gen.sv
// Free-running PRBS9 generator; one bit per enabled clock, output straight from the LFSR MSB.
module prbs9_gen
  import prbs_pkg::*;
#(
  parameter logic [PRBS9_W-1:0] SEED = PRBS9_DEFAULT_SEED
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_out
);

  // An all-zero seed would lock the LFSR, so it falls back to the default.
  localparam logic [PRBS9_W-1:0] SEED_EFF = (SEED == '0) ? PRBS9_DEFAULT_SEED : SEED;

  logic [PRBS9_W-1:0] state;
  logic [PRBS9_W-1:0] next;

  prbs9_lfsr_step u_step (
    .state (state),
    .next  (next)
  );

  // State register: reset reloads the seed and wins over enable; enable advances, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED_EFF;
    end else if (enable) begin
      state <= next;
    end
  end

  assign bit_out = state[PRBS9_TAP_HI];

endmodule

// File: tb/tb_prbs9_gen.sv
// Self-checking bench for prbs9_gen: three seeds checked against a bit-recurrence reference model.
module tb_prbs9_gen;
  import prbs_pkg::*;

  localparam int unsigned NDUT = 3;
  localparam int unsigned GLEN = 1200;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic bit_a, bit_b, bit_c;
  logic [NDUT-1:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  // Reference bit streams per DUT, generated from the output recurrence.
  bit gold [NDUT][GLEN];

  always #5 clk = ~clk;

  prbs9_gen #(.SEED(9'h1FF)) dut_a (.clk(clk), .rst(rst), .enable(enable), .bit_out(bit_a));
  prbs9_gen #(.SEED(9'h001)) dut_b (.clk(clk), .rst(rst), .enable(enable), .bit_out(bit_b));
  prbs9_gen #(.SEED(9'h000)) dut_c (.clk(clk), .rst(rst), .enable(enable), .bit_out(bit_c));

  assign obs = {bit_c, bit_b, bit_a};

  // First nine bits are the seed MSB-first; afterwards out[n] = out[n-9] ^ out[n-5].
  task automatic build_gold(input int k, input logic [8:0] seed);
    for (int i = 0; i < GLEN; i++) begin
      if (i < 9) gold[k][i] = seed[8-i];
      else       gold[k][i] = gold[k][i-9] ^ gold[k][i-5];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic en);
    rst = 1'b1;
    enable = en;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    n_checks++;
    if (obs !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", obs, 3'b101);
    end
  endtask

  task automatic test_first16();
    logic [15:0] got_a;
    logic [8:0]  got_b;
    logic [15:0] got_c;
    apply_reset(1'b1);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got_a[15-i] = bit_a;
      got_c[15-i] = bit_c;
      if (i < 9) got_b[8-i] = bit_b;
      tick();
    end
    n_checks++;
    if (got_a !== 16'hFF83) begin
      n_fail++;
      $display("FAIL first16_seed1ff: got %h expected %h", got_a, 16'hFF83);
    end
    n_checks++;
    if (got_b !== 9'b000000001) begin
      n_fail++;
      $display("FAIL first9_seed001: got %b expected %b", got_b, 9'b000000001);
    end
    n_checks++;
    if (got_c !== 16'hFF83) begin
      n_fail++;
      $display("FAIL first16_seed000: got %h expected %h", got_c, 16'hFF83);
    end
  endtask

  task automatic test_period();
    bit obs_a [2*PRBS9_PERIOD];
    int bad_model [NDUT];
    int bad_rep, ones, run, max1, max0;
    bad_model = '{default: 0};
    apply_reset(1'b0);
    enable = 1'b1;
    for (int i = 0; i < 2*PRBS9_PERIOD; i++) begin
      obs_a[i] = bit_a;
      for (int k = 0; k < NDUT; k++)
        if (obs[k] !== gold[k][i]) bad_model[k]++;
      tick();
    end
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (bad_model[k] != 0) begin
        n_fail++;
        $display("FAIL period_model_dut%0d: got %0d mismatching bits expected 0", k, bad_model[k]);
      end
    end
    bad_rep = 0;
    ones = 0;
    max1 = 0;
    max0 = 0;
    run = 0;
    for (int i = 0; i < PRBS9_PERIOD; i++) begin
      if (obs_a[i] != obs_a[i+PRBS9_PERIOD]) bad_rep++;
      if (obs_a[i]) ones++;
      if (i > 0 && obs_a[i] == obs_a[i-1]) run++;
      else run = 1;
      if (obs_a[i] && run > max1) max1 = run;
      if (!obs_a[i] && run > max0) max0 = run;
    end
    n_checks++;
    if (bad_rep != 0) begin
      n_fail++;
      $display("FAIL period_repeat: got %0d differing bits expected 0", bad_rep);
    end
    n_checks++;
    if (ones != 256) begin
      n_fail++;
      $display("FAIL ones_count: got %0d expected 256", ones);
    end
    n_checks++;
    if (max1 != 9 || max0 != 8) begin
      n_fail++;
      $display("FAIL max_runs: got ones=%0d zeros=%0d expected ones=9 zeros=8", max1, max0);
    end
  endtask

  task automatic test_enable_gap();
    int idx = 0;
    int bad = 0;
    int bad_hold = 0;
    apply_reset(1'b1);
    enable = 1'b1;
    while (idx < 37) begin
      if (obs !== {gold[2][idx], gold[1][idx], gold[0][idx]}) bad++;
      tick();
      idx++;
    end
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs !== {gold[2][37], gold[1][37], gold[0][37]}) bad_hold++;
    end
    n_checks++;
    if (bad_hold != 0) begin
      n_fail++;
      $display("FAIL gap_hold: got %0d changed samples expected 0", bad_hold);
    end
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (obs !== {gold[2][idx], gold[1][idx], gold[0][idx]}) bad++;
      tick();
      idx++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL gap_stream: got %0d mismatches expected 0", bad);
    end
  endtask

  task automatic test_random_enable();
    int idx = 0;
    int bad = 0;
    logic en;
    apply_reset(1'($urandom_range(0, 1)));
    for (int i = 0; i < 600; i++) begin
      en = 1'($urandom_range(0, 1));
      enable = en;
      tick();
      if (en) idx++;
      if (obs !== {gold[2][idx], gold[1][idx], gold[0][idx]}) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL random_enable: got %0d mismatches expected 0 at enabled index %0d", bad, idx);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] got;
    apply_reset(1'b0);
    enable = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    apply_reset(1'b1);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      got[15-i] = bit_a;
      tick();
    end
    n_checks++;
    if (got !== 16'hFF83) begin
      n_fail++;
      $display("FAIL mid_reset: got %h expected %h", got, 16'hFF83);
    end
  endtask

  task automatic test_reset_no_enable();
    apply_reset(1'b1);
    enable = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    n_checks++;
    if (bit_a !== gold[0][12]) begin
      n_fail++;
      $display("FAIL pre_reset_bit: got %b expected %b", bit_a, gold[0][12]);
    end
    apply_reset(1'b0);
    enable = 1'b0;
    n_checks++;
    if (obs !== 3'b101) begin
      n_fail++;
      $display("FAIL reset_no_enable: got %b expected %b", obs, 3'b101);
    end
    tick();
    enable = 1'b1;
    tick();
    n_checks++;
    if (obs !== {gold[2][1], gold[1][1], gold[0][1]}) begin
      n_fail++;
      $display("FAIL after_reload_step: got %b expected %b", obs, {gold[2][1], gold[1][1], gold[0][1]});
    end
  endtask

  initial begin
    build_gold(0, 9'h1FF);
    build_gold(1, 9'h001);
    build_gold(2, PRBS9_DEFAULT_SEED);
    repeat (2) tick();
    test_reset();
    test_first16();
    test_period();
    test_enable_gap();
    test_random_enable();
    test_mid_reset();
    test_reset_no_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs9_gen.md
Name: prbs9_gen

Overview:
- Free-running PRBS9 pseudo-random bit generator.
- Uses a 9-bit Fibonacci LFSR with polynomial x^9 + x^5 + 1 and emits one bit per enabled clock cycle.
- Serves as the pattern source for serial-link and BER test paths.
- Clocked by the 100 MHz board clock; driven by the board reset.

Parameters:
- SEED, 9'h1FF, LFSR load value on reset. Must be nonzero; a value of 0 is replaced internally by 9'h1FF.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- enable  input  1  advance enable. 1 = shift LFSR this cycle; 0 = hold.
- bit_out  output  1  current PRBS bit, taken directly from a flop (LFSR MSB).

Behaviour:
- One clock; reset is synchronous and active-high.
- State: 9-bit register state[8:0].
- bit_out = state[8] at all times. No combinational path from inputs to bit_out.
- Reset: on a rising clk with rst=1, state <= SEED, regardless of enable.
  - bit_out equals SEED[8] (1 for the default) from the cycle after the reset edge.
  - rst has priority over enable.
- Shift: on a rising clk with rst=0 and enable=1:
  - fb = state[8] ^ state[4]
  - state <= {state[7:0], fb}
- Hold: rst=0 and enable=0 → state unchanged, bit_out static.
- Latency: the first 9 enabled output bits after reset are SEED[8] down to SEED[0]; every later bit out[n+9] = out[n] ^ out[n+4].
- Default seed sequence, first 16 bits after reset (MSB first): 1111_1111_1000_0011 = 16'hFF83.
- Period: 511 enabled cycles. The state visits all 511 nonzero values and never reaches 0.
- Per period: 256 ones and 255 zeros; longest run of ones = 9, longest run of zeros = 8.
- Enable toggling: gaps in enable only stretch the sequence in time. The enabled-cycle bit order is identical to continuous enable.
- Reset mid-sequence: the next edge reloads SEED; the sequence restarts from bit 0.
- Power-up before the first reset: state is undefined. The bench only checks after reset.

Decomposition:
- Shared package prbs_pkg:
  - PRBS9_W = 9
  - PRBS9_TAP_HI = 8, PRBS9_TAP_LO = 4
  - PRBS9_DEFAULT_SEED = 9'h1FF
  - PRBS9_PERIOD = 511
  - function prbs9_next(state) returning the shifted state; reused by checkers and the bench model.
- One sub-module is natural: prbs9_lfsr_step, combinational, state in → next state out. The top holds the register, the reset/enable muxing and the SEED sanitising.

Test Plan:
- Reset then continuous enable, SEED=9'h1FF → bit_out first 16 samples = 1,1,1,1,1,1,1,1,1,0,0,0,0,0,1,1 (16'hFF83).
- Continuous enable for 1022 cycles → bits 511..1021 equal bits 0..510; 256 ones per 511 bits; max ones-run 9, max zeros-run 8; internal state never 0.
- enable=0 for 20 cycles at bit index 37, then re-enable → bit_out constant during the gap; the compressed enabled-bit stream matches the golden model exactly.
- Assert rst=1 at cycle 300 for one cycle with enable=1 → next 16 bits again 16'hFF83.
- Assert rst=1 with enable=0 → state reloads to SEED anyway; bit_out = 1 the following cycle.
- SEED=9'h001, then SEED=9'h000 → first 9 bits 000000001 for 9'h001; SEED=0 behaves identically to 9'h1FF (16'hFF83).
